uart_reg_bridge: RTL and testbench

Command-frame parser that sits directly downstream of uart_top's receive side and upstream of its transmit side. It consumes received bytes (data_received / rx_ready_tick), decodes host read/write frames, and drives a simple internal register bus. It returns a one-byte response through uart_top's transmit handshake (data_to_send / tx_start_tick / tx_busy).

---
 rtl/uart_reg_bridge_if.sv | 25 ++
 rtl/uart_reg_bridge.sv | 153 +++++++++++++++
 tb/tb_uart_reg_bridge.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_reg_bridge_if.sv
// Bus bundle between the frame parser, the UART byte handshake and the
// internal register bus. The bridge is the master; the UART and the
// register file together form the slave side.
interface uart_reg_bridge_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  modport master (
    input  rx_data, rx_valid, tx_busy, reg_rdata,
    output tx_data, tx_start, reg_addr, reg_wdata, reg_we, reg_re
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, reg_rdata,
    input  tx_data, tx_start, reg_addr, reg_wdata, reg_we, reg_re
  );
endinterface

// File: rtl/uart_reg_bridge.sv
// Host command-frame parser: SYNC, CMD, ADDR, [DATA], CHK frames arriving
// from the UART receiver become register-bus reads/writes, and a one-byte
// response (ACK, read data or NAK) goes back through the UART transmitter.
module uart_reg_bridge #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter logic [7:0]  ACK_BYTE     = 8'h06,
  parameter logic [7:0]  NAK_BYTE     = 8'h15,
  parameter int unsigned TIMEOUT_CLKS = 125000
) (
  input  logic                clk,
  input  logic                reset_n,
  uart_reg_bridge_if.master   bus,
  output logic                busy,
  output logic [7:0]          nak_count
);

  localparam logic [7:0]  CMD_WRITE = 8'h01;
  localparam logic [7:0]  CMD_READ  = 8'h02;
  localparam int unsigned TW        = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR, DATA, CHK, EXEC, READ_WAIT, RESP, TX_WAIT
  } state_t;

  state_t        state_reg;
  logic [TW-1:0] timeout_reg;
  logic [7:0]    cmd_reg;
  logic [7:0]    addr_reg;
  logic [7:0]    data_reg;
  logic [7:0]    resp_reg;
  logic          read_pending_reg;
  logic          nak_pending_reg;
  logic          seen_busy_reg;
  logic [7:0]    tx_data_reg;
  logic          tx_start_reg;
  logic [7:0]    reg_addr_reg;
  logic [7:0]    reg_wdata_reg;
  logic          reg_we_reg;
  logic          reg_re_reg;
  logic [7:0]    nak_count_reg;
  logic [7:0]    chk_expected;

  // DATA only participates in the checksum for a write frame.
  assign chk_expected = cmd_reg ^ addr_reg ^ ((cmd_reg == CMD_WRITE) ? data_reg : 8'h00);

  assign bus.tx_data   = tx_data_reg;
  assign bus.tx_start  = tx_start_reg;
  assign bus.reg_addr  = reg_addr_reg;
  assign bus.reg_wdata = reg_wdata_reg;
  assign bus.reg_we    = reg_we_reg;
  assign bus.reg_re    = reg_re_reg;
  assign busy          = (state_reg != IDLE);
  assign nak_count     = nak_count_reg;

  // Frame parser, bus strobes, response handshake and inter-byte timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      timeout_reg      <= '0;
      cmd_reg          <= '0;
      addr_reg         <= '0;
      data_reg         <= '0;
      resp_reg         <= '0;
      read_pending_reg <= 1'b0;
      nak_pending_reg  <= 1'b0;
      seen_busy_reg    <= 1'b0;
      tx_data_reg      <= '0;
      tx_start_reg     <= 1'b0;
      reg_addr_reg     <= '0;
      reg_wdata_reg    <= '0;
      reg_we_reg       <= 1'b0;
      reg_re_reg       <= 1'b0;
      nak_count_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          timeout_reg <= '0;
          if (bus.rx_valid && bus.rx_data == SYNC_BYTE) state_reg <= CMD;
        end
        CMD, ADDR, DATA, CHK: begin
          if (bus.rx_valid) begin
            timeout_reg <= '0;
            case (state_reg)
              CMD: begin
                cmd_reg   <= bus.rx_data;
                state_reg <= ADDR;
              end
              ADDR: begin
                addr_reg  <= bus.rx_data;
                state_reg <= (cmd_reg == CMD_WRITE) ? DATA : CHK;
              end
              DATA: begin
                data_reg  <= bus.rx_data;
                state_reg <= CHK;
              end
              default: begin
                // Strobes go out on this edge so they appear one cycle after CHK.
                read_pending_reg <= 1'b0;
                nak_pending_reg  <= 1'b0;
                if (bus.rx_data == chk_expected && cmd_reg == CMD_WRITE) begin
                  reg_we_reg    <= 1'b1;
                  reg_addr_reg  <= addr_reg;
                  reg_wdata_reg <= data_reg;
                  resp_reg      <= ACK_BYTE;
                end else if (bus.rx_data == chk_expected && cmd_reg == CMD_READ) begin
                  reg_re_reg       <= 1'b1;
                  reg_addr_reg     <= addr_reg;
                  read_pending_reg <= 1'b1;
                end else begin
                  resp_reg        <= NAK_BYTE;
                  nak_pending_reg <= 1'b1;
                end
                state_reg <= EXEC;
              end
            endcase
          end else if (timeout_reg == TMAX) begin
            timeout_reg <= '0;
            state_reg   <= IDLE;
          end else begin
            timeout_reg <= timeout_reg + TW'(1);
          end
        end
        EXEC: begin
          reg_we_reg <= 1'b0;
          reg_re_reg <= 1'b0;
          if (nak_pending_reg && nak_count_reg != 8'hFF) nak_count_reg <= nak_count_reg + 8'd1;
          state_reg <= read_pending_reg ? READ_WAIT : RESP;
        end
        READ_WAIT: begin
          resp_reg  <= bus.reg_rdata;
          state_reg <= RESP;
        end
        RESP: begin
          if (!bus.tx_busy) begin
            tx_data_reg   <= resp_reg;
            tx_start_reg  <= 1'b1;
            seen_busy_reg <= 1'b0;
            state_reg     <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          // The transmitter may raise tx_busy a cycle late; wait for a full high-low cycle.
          tx_start_reg <= 1'b0;
          if (bus.tx_busy) seen_busy_reg <= 1'b1;
          else if (seen_busy_reg) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Self-checking bench for uart_reg_bridge: directed frames from the test
// plan, a timeout case, a mid-response reset, randomized frames and NAK
// counter saturation, all checked against a frame-level reference model.
module tb_uart_reg_bridge;
  localparam int PER = 10;
  localparam int TO  = 1000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       busy;
  logic [7:0] nak_count;

  uart_reg_bridge_if bus ();

  uart_reg_bridge #(.TIMEOUT_CLKS(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.master),
    .busy      (busy),
    .nak_count (nak_count)
  );

  always #(PER/2) clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_ge(input string nm, input int act, input int min);
    n_checks++;
    if (act < min) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected at least %0d", nm, act, min);
    end
  endtask

  // Register-file responder: read data valid the cycle after reg_re.
  logic [7:0] slv_mem [256];
  logic [7:0] rdata_q = 8'h00;
  bit         slv_init = 1'b0;
  always @(posedge clk) begin
    if (!slv_init) begin
      for (int i = 0; i < 256; i++) slv_mem[i] <= 8'(i) ^ 8'h4A;
      slv_init <= 1'b1;
    end else begin
      if (bus.reg_we) slv_mem[bus.reg_addr] <= bus.reg_wdata;
      if (bus.reg_re) rdata_q <= slv_mem[bus.reg_addr];
    end
  end
  assign bus.reg_rdata = rdata_q;

  // Transmitter responder: busy for a few cycles starting after tx_start.
  int tx_cnt = 0;
  always @(posedge clk) begin
    if (bus.tx_start) tx_cnt <= int'($urandom_range(2, 6));
    else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
  end
  assign bus.tx_busy = (tx_cnt != 0);

  // Reference model state.
  logic [7:0] model_mem [256];
  int         model_nak = 0;

  // Observed events.
  logic [7:0] we_a_q[$], we_d_q[$], re_a_q[$], tx_d_q[$];
  time        we_t_q[$], re_t_q[$], tx_t_q[$];
  bit         prev_we = 1'b0, prev_re = 1'b0, prev_tx = 1'b0;

  // Per-cycle compare: strobe rules, and idle-state outputs against the model.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_we <= 1'b0;
      prev_re <= 1'b0;
      prev_tx <= 1'b0;
    end else begin
      check("we_re_exclusive", int'(bus.reg_we & bus.reg_re), 0);
      if (bus.reg_we) begin
        check("we_width", int'(prev_we), 0);
        we_a_q.push_back(bus.reg_addr);
        we_d_q.push_back(bus.reg_wdata);
        we_t_q.push_back($time);
      end
      if (bus.reg_re) begin
        check("re_width", int'(prev_re), 0);
        re_a_q.push_back(bus.reg_addr);
        re_t_q.push_back($time);
      end
      if (bus.tx_start) begin
        check("tx_start_width", int'(prev_tx), 0);
        tx_d_q.push_back(bus.tx_data);
        tx_t_q.push_back($time);
      end
      if (!busy) begin
        check("idle_nak_count", int'(nak_count), model_nak);
        check("idle_no_strobe", int'({bus.reg_we, bus.reg_re, bus.tx_start}), 0);
      end
      prev_we <= bus.reg_we;
      prev_re <= bus.reg_re;
      prev_tx <= bus.tx_start;
    end
  end

  task automatic clear_events();
    we_a_q.delete(); we_d_q.delete(); we_t_q.delete();
    re_a_q.delete(); re_t_q.delete();
    tx_d_q.delete(); tx_t_q.delete();
  endtask

  // Called on a falling edge; returns on the next falling edge with rx_valid low.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr,
                           input logic [7:0] data, input logic [7:0] chk,
                           input bit junk, output logic [7:0] got);
    logic [7:0] exp_chk, exp_resp;
    bit         is_w, is_r, is_n, done;
    time        t_chk;
    exp_chk  = cmd ^ addr ^ ((cmd == 8'h01) ? data : 8'h00);
    is_w     = (chk == exp_chk) && (cmd == 8'h01);
    is_r     = (chk == exp_chk) && (cmd == 8'h02);
    is_n     = !(is_w || is_r);
    exp_resp = is_w ? 8'h06 : (is_r ? model_mem[addr] : 8'h15);
    clear_events();
    @(negedge clk);
    send_byte(8'hA5); gap();
    send_byte(cmd);   gap();
    send_byte(addr);  gap();
    if (cmd == 8'h01) begin
      send_byte(data); gap();
    end
    t_chk = $time;
    if (is_w) model_mem[addr] = data;
    if (is_n) model_nak = (model_nak < 255) ? model_nak + 1 : 255;
    send_byte(chk);
    if (junk) send_byte(8'hA5);
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      #1;
      if (tx_d_q.size() >= 1 && !busy) done = 1'b1;
    end
    check("frame_completes", int'(done), 1);
    check("tx_count", tx_d_q.size(), 1);
    if (tx_d_q.size() > 0) begin
      check("tx_data", int'(tx_d_q[0]), int'(exp_resp));
      check_ge("tx_latency", int'((tx_t_q[0] - t_chk) / PER), is_r ? 3 : 2);
    end
    check("we_count", we_a_q.size(), int'(is_w));
    check("re_count", re_a_q.size(), int'(is_r));
    if (is_w && we_a_q.size() > 0) begin
      check("we_addr", int'(we_a_q[0]), int'(addr));
      check("we_data", int'(we_d_q[0]), int'(data));
      check("we_latency", int'((we_t_q[0] - t_chk) / PER), 1);
    end
    if (is_r && re_a_q.size() > 0) begin
      check("re_addr", int'(re_a_q[0]), int'(addr));
      check("re_latency", int'((re_t_q[0] - t_chk) / PER), 1);
    end
    got = (tx_d_q.size() > 0) ? tx_d_q[0] : 8'h00;
    $display("frame cmd=%02h addr=%02h data=%02h chk=%02h junk=%0d -> resp=%02h (model %02h) nak_count=%0d",
             cmd, addr, data, chk, junk, got, exp_resp, nak_count);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_tx_start"},  int'(bus.tx_start), 0);
    check({nm, "_tx_data"},   int'(bus.tx_data), 0);
    check({nm, "_reg_we"},    int'(bus.reg_we), 0);
    check({nm, "_reg_re"},    int'(bus.reg_re), 0);
    check({nm, "_reg_addr"},  int'(bus.reg_addr), 0);
    check({nm, "_reg_wdata"}, int'(bus.reg_wdata), 0);
    check({nm, "_busy"},      int'(busy), 0);
    check({nm, "_nak_count"}, int'(nak_count), 0);
  endtask

  initial begin
    logic [7:0] got, cmd, addr, data, chk;
    bit         done;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'(i) ^ 8'h4A;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    // Directed frames with hand-computed responses.
    run_frame(8'h02, 8'h10, 8'h00, 8'h12, 1'b0, got);
    check("pin_read_10", int'(got), 8'h5A);
    run_frame(8'h01, 8'h10, 8'h3C, 8'h2D, 1'b0, got);
    check("pin_write_ack", int'(got), 8'h06);
    check("pin_reg_addr_hold", int'(bus.reg_addr), 8'h10);
    check("pin_reg_wdata_hold", int'(bus.reg_wdata), 8'h3C);
    run_frame(8'h01, 8'h10, 8'h3C, 8'h00, 1'b0, got);
    check("pin_badchk_nak", int'(got), 8'h15);
    check("pin_nak_count_1", int'(nak_count), 1);
    run_frame(8'h07, 8'h20, 8'h00, 8'h27, 1'b0, got);
    check("pin_unknown_nak", int'(got), 8'h15);
    check("pin_nak_count_2", int'(nak_count), 2);
    @(negedge clk);
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
    run_frame(8'h02, 8'h20, 8'h00, 8'h22, 1'b1, got);
    check("pin_garbage_read_20", int'(got), 8'h6A);
    run_frame(8'h01, 8'hA5, 8'hA5, 8'h01, 1'b1, got);
    check("pin_midframe_sync_ack", int'(got), 8'h06);
    check("pin_midframe_sync_addr", int'(bus.reg_addr), 8'hA5);

    // Inter-byte timeout abandons a partial frame silently.
    clear_events();
    @(negedge clk);
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TO - 100) @(negedge clk);
    check("timeout_still_busy", int'(busy), 1);
    repeat (200) @(negedge clk);
    check("timeout_idle", int'(busy), 0);
    check("timeout_no_tx", tx_d_q.size(), 0);
    check("timeout_no_bus", we_a_q.size() + re_a_q.size(), 0);
    $display("timeout frame A5 01 abandoned, busy=%0d", busy);
    run_frame(8'h01, 8'h44, 8'h99, 8'hDC, 1'b0, got);
    check("pin_after_timeout_ack", int'(got), 8'h06);

    // Reset while the response pulse is on the wire.
    clear_events();
    @(negedge clk);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h12);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      #1;
      if (tx_d_q.size() > 0) done = 1'b1;
    end
    check("reset_case_tx_seen", int'(done), 1);
    if (done) check("reset_case_tx_data", int'(tx_d_q[0]), 8'h3C);
    reset_n = 1'b0;
    model_nak = 0;
    #1;
    check_all_zero("async_reset");
    repeat (3) @(negedge clk);
    check_all_zero("held_reset");
    reset_n = 1'b1;
    $display("reset asserted during response, outputs cleared");
    run_frame(8'h02, 8'h10, 8'h00, 8'h12, 1'b0, got);
    check("pin_after_reset_read", int'(got), 8'h3C);

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0, 1:    cmd = 8'h01;
        2, 3:    cmd = 8'h02;
        4:       cmd = 8'h07;
        default: cmd = 8'($urandom);
      endcase
      addr = 8'($urandom);
      data = 8'($urandom);
      chk  = cmd ^ addr ^ ((cmd == 8'h01) ? data : 8'h00);
      if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      run_frame(cmd, addr, data, chk, 1'($urandom_range(0, 1)), got);
    end

    // Drive the NAK counter to saturation and beyond.
    while (model_nak < 255) run_frame(8'h07, 8'h00, 8'h00, 8'h07, 1'b0, got);
    run_frame(8'h01, 8'h00, 8'h00, 8'h55, 1'b0, got);
    run_frame(8'h07, 8'h01, 8'h00, 8'h06, 1'b0, got);
    check("pin_nak_saturated", int'(nak_count), 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
